// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: N managers share one decoder port, one transaction at a time.
// A watchdog forces an error ack with 32'hDEAD_BEEF when the decoder stalls too long.
//
// state | meaning
// IDLE  | no owner, all outputs 0, round-robin pick of the next requester
// BUSY  | granted manager routed to the decoder until ack, timeout or abort
module wishbone_arbiter #(
  parameter int NUM_MANAGERS   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_MANAGERS-1:0]     wbm_cyc_i,
  input  logic [NUM_MANAGERS-1:0]     wbm_stb_i,
  input  logic [NUM_MANAGERS-1:0]     wbm_we_i,
  input  logic [32*NUM_MANAGERS-1:0]  wbm_adr_i,
  input  logic [32*NUM_MANAGERS-1:0]  wbm_dat_i,
  input  logic [4*NUM_MANAGERS-1:0]   wbm_sel_i,
  output logic [NUM_MANAGERS-1:0]     wbm_ack_o,
  output logic [32*NUM_MANAGERS-1:0]  wbm_dat_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  output logic [31:0]                 wbs_adr_o,
  output logic [31:0]                 wbs_dat_o,
  output logic [3:0]                  wbs_sel_o,
  input  logic                        wbs_ack_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic [NUM_MANAGERS-1:0]     grant_o,
  output logic                        timeout_o
);

  localparam int          IDXW     = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [IDXW-1:0]         gnt_idx, gnt_nxt;
  logic [IDXW-1:0]         last_grant, last_nxt;
  logic [IDXW-1:0]         pick, cand;
  logic [15:0]             wait_cnt, cnt_nxt;
  logic [NUM_MANAGERS-1:0] req;
  logic                    found;

  logic [31:0] adr_arr  [NUM_MANAGERS];
  logic [31:0] wdat_arr [NUM_MANAGERS];
  logic [31:0] rdat_arr [NUM_MANAGERS];
  logic [3:0]  sel_arr  [NUM_MANAGERS];

  for (genvar g = 0; g < NUM_MANAGERS; g++) begin : g_slice
    assign adr_arr[g]           = wbm_adr_i[g*32 +: 32];
    assign wdat_arr[g]          = wbm_dat_i[g*32 +: 32];
    assign sel_arr[g]           = wbm_sel_i[g*4 +: 4];
    assign wbm_dat_o[g*32 +: 32] = rdat_arr[g];
  end

  assign req = wbm_cyc_i & wbm_stb_i;

  // Scan starts just after the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_MANAGERS; k++) begin
      cand = IDXW'((int'(last_grant) + k) % NUM_MANAGERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_idx;
    last_nxt  = last_grant;
    cnt_nxt   = wait_cnt;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbm_ack_o = '0;
    grant_o   = '0;
    timeout_o = 1'b0;
    for (int i = 0; i < NUM_MANAGERS; i++) rdat_arr[i] = '0;

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          gnt_nxt   = pick;
          last_nxt  = pick;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        grant_o[gnt_idx] = 1'b1;
        if (!wbm_cyc_i[gnt_idx]) begin
          state_nxt = IDLE;
        end else begin
          wbs_cyc_o = 1'b1;
          wbs_stb_o = wbm_stb_i[gnt_idx];
          wbs_we_o  = wbm_we_i[gnt_idx];
          wbs_adr_o = adr_arr[gnt_idx];
          wbs_dat_o = wdat_arr[gnt_idx];
          wbs_sel_o = sel_arr[gnt_idx];
          if (wbs_ack_i) begin
            wbm_ack_o[gnt_idx] = 1'b1;
            rdat_arr[gnt_idx]  = wbs_dat_i;
            state_nxt          = IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LIMIT)) begin
            // Pull the strobe so the stalled slave sees the transaction end.
            wbs_cyc_o          = 1'b0;
            wbs_stb_o          = 1'b0;
            wbm_ack_o[gnt_idx] = 1'b1;
            rdat_arr[gnt_idx]  = ERR_DATA;
            timeout_o          = 1'b1;
            state_nxt          = IDLE;
          end else if (wait_cnt != 16'hFFFF) begin
            cnt_nxt = wait_cnt + 16'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      last_grant <= IDXW'(NUM_MANAGERS - 1);
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      gnt_idx    <= gnt_nxt;
      last_grant <= last_nxt;
      wait_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: reset, read, timeout, contention, abort, ack/timeout collision.
// Expected acks are queued when a response is arranged and popped when the DUT acks.
module tb_wishbone_arbiter;
  localparam int N = 3;

  logic            CLK, nRST;
  logic [N-1:0]    wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [32*N-1:0] wbm_adr_i, wbm_dat_i;
  logic [4*N-1:0]  wbm_sel_i;
  logic [N-1:0]    wbm_ack_o;
  logic [32*N-1:0] wbm_dat_o;
  logic            wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [31:0]     wbs_adr_o, wbs_dat_o;
  logic [3:0]      wbs_sel_o;
  logic            wbs_ack_i;
  logic [31:0]     wbs_dat_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  wishbone_arbiter #(.NUM_MANAGERS(N), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_ack_o(wbm_ack_o), .wbm_dat_o(wbm_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_ack_i(wbs_ack_i), .wbs_dat_i(wbs_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          mgr;
    logic [31:0] dat;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mgr(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbm_cyc_i[m]         = cyc;
    wbm_stb_i[m]         = stb;
    wbm_we_i[m]          = we;
    wbm_adr_i[m*32 +: 32] = adr;
    wbm_dat_i[m*32 +: 32] = dat;
    wbm_sel_i[m*4 +: 4]   = sel;
  endtask

  task automatic push(input int m, input logic [31:0] d, input logic to);
    exp_t e;
    e.mgr = m;
    e.dat = d;
    e.to  = to;
    sb.push_back(e);
  endtask

  // Samples on falling edges until any ack (bounded), then checks it against the queue head.
  task automatic wait_ack(input int budget, output int n);
    exp_t e;
    logic got;
    n   = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      @(negedge CLK);
      n++;
      if (|wbm_ack_o) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_vec", 32'(wbm_ack_o), 32'(1 << e.mgr));
      chk("ack_dat", wbm_dat_o[e.mgr*32 +: 32], e.dat);
      chk("timeout_flag", 32'(timeout_o), 32'(e.to));
      for (int i = 0; i < N; i++)
        if (i != e.mgr) chk("dat_other", wbm_dat_o[i*32 +: 32], 32'd0);
    end
  endtask

  initial begin
    int n;
    nRST      = 1'b0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbs_ack_i = 1'b0; wbs_dat_i = '0;

    // Reset with everyone requesting
    set_mgr(0, 1, 1, 0, 32'h1000_0000, 32'h0, 4'hF);
    set_mgr(1, 1, 1, 0, 32'h1100_0000, 32'h0, 4'hF);
    set_mgr(2, 1, 1, 0, 32'h1200_0000, 32'h0, 4'hF);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbs_stb_o), 32'd0);
    chk("rst_adr", wbs_adr_o, 32'd0);
    chk("rst_ack", 32'(wbm_ack_o), 32'd0);
    chk("rst_dat", 32'(|wbm_dat_o), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("first_grant", 32'(grant_o), 32'b001);
    chk("first_adr", wbs_adr_o, 32'h1000_0000);
    tick();
    wbm_cyc_i = '0; wbm_stb_i = '0;
    @(negedge CLK);
    chk("abort0_cyc", 32'(wbs_cyc_o), 32'd0);

    // Single read by manager 1, decoder acks on the third BUSY cycle
    tick();
    set_mgr(1, 1, 1, 0, 32'h3300_0010, 32'h0, 4'hF);
    @(negedge CLK);
    chk("read_latency_stb", 32'(wbs_stb_o), 32'd0);
    tick();
    @(negedge CLK);
    chk("read_grant", 32'(grant_o), 32'b010);
    chk("read_adr", wbs_adr_o, 32'h3300_0010);
    chk("read_stb", 32'(wbs_stb_o), 32'd1);
    chk("read_sel", 32'(wbs_sel_o), 32'hF);
    tick();
    tick();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h1234_5678;
    push(1, 32'h1234_5678, 1'b0);
    wait_ack(5, n);
    chk("read_ack_lat", n, 32'd1);
    tick();
    wbs_ack_i = 1'b0;
    set_mgr(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk("read_ack_1cyc", 32'(wbm_ack_o), 32'd0);

    // Timeout: manager 2 writes, decoder never responds
    tick();
    set_mgr(2, 1, 1, 1, 32'h4400_0020, 32'hA5A5_A5A5, 4'h3);
    push(2, 32'hDEAD_BEEF, 1'b1);
    wait_ack(20, n);
    chk("to_cycle", n, 32'd10);
    chk("to_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("to_stb", 32'(wbs_stb_o), 32'd0);
    tick();
    set_mgr(2, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk("to_pulse_end", 32'(timeout_o), 32'd0);
    chk("to_idle", 32'(grant_o), 32'd0);

    // Contention: all three request, served 0,1,2 with an IDLE gap between
    tick();
    for (int m = 0; m < N; m++) set_mgr(m, 1, 1, 0, 32'h5000_0000 + 32'(m), 32'h0, 4'hF);
    @(negedge CLK);
    for (int m = 0; m < N; m++) begin
      @(negedge CLK);
      chk("rr_grant", 32'(grant_o), 32'(1 << m));
      chk("rr_adr", wbs_adr_o, 32'h5000_0000 + 32'(m));
      tick();
      wbs_ack_i = 1'b1; wbs_dat_i = 32'h0000_0100 + 32'(m);
      push(m, 32'h0000_0100 + 32'(m), 1'b0);
      wait_ack(5, n);
      chk("rr_ack_lat", n, 32'd1);
      tick();
      wbs_ack_i = 1'b0;
      set_mgr(m, 0, 0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge CLK);
      chk("rr_idle_gap", 32'(grant_o), 32'd0);
      if (m < N - 1) tick();
    end

    // Abort: manager 0 drops cyc in its 2nd BUSY cycle, manager 1 waiting
    tick();
    set_mgr(0, 1, 1, 0, 32'h6000_0000, 32'h0, 4'hF);
    set_mgr(1, 1, 1, 0, 32'h6100_0000, 32'h0, 4'hF);
    tick();
    @(negedge CLK);
    chk("abort_grant", 32'(grant_o), 32'b001);
    tick();
    wbm_cyc_i[0] = 1'b0;
    @(negedge CLK);
    chk("abort_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("abort_noack", 32'(wbm_ack_o), 32'd0);
    tick();
    @(negedge CLK);
    chk("abort_idle", 32'(grant_o), 32'd0);
    tick();
    @(negedge CLK);
    chk("abort_next", 32'(grant_o), 32'b010);
    tick();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h0BAD_CAFE;
    push(1, 32'h0BAD_CAFE, 1'b0);
    wait_ack(5, n);
    tick();
    wbs_ack_i = 1'b0;
    set_mgr(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_mgr(1, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Real ack lands exactly when the counter reaches the limit
    tick();
    set_mgr(2, 1, 1, 0, 32'h7000_0000, 32'h0, 4'hF);
    repeat (9) tick();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_F00D;
    push(2, 32'hCAFE_F00D, 1'b0);
    wait_ack(5, n);
    chk("coll_lat", n, 32'd1);
    chk("coll_cyc", 32'(wbs_cyc_o), 32'd1);
    tick();
    wbs_ack_i = 1'b0;
    set_mgr(2, 0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Reset asserted mid-BUSY while the decoder acks
    tick();
    set_mgr(0, 1, 1, 0, 32'h8000_0000, 32'h0, 4'hF);
    tick();
    nRST = 1'b0;
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h1111_2222;
    @(negedge CLK);
    chk("midrst_ack", 32'(wbm_ack_o), 32'd0);
    chk("midrst_grant", 32'(grant_o), 32'd0);
    chk("midrst_cyc", 32'(wbs_cyc_o), 32'd0);
    tick();
    nRST = 1'b1;
    wbs_ack_i = 1'b0;
    set_mgr(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    chk("midrst_idle", 32'(grant_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NUM_MANAGERS, default 3, meaning the number of upstream Wishbone managers (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the BUSY cycles without ack before a forced error ack (0 = timeout disabled, max 65535).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports wbm_cyc_i, wbm_stb_i, wbm_we_i, input, NUM_MANAGERS bits each: per-manager cycle, strobe and write-enable.
REQ-006 SHALL have ports wbm_adr_i and wbm_dat_i, input, 32*NUM_MANAGERS bits each, flat, manager i at [i*32 +: 32]: address and write data.
REQ-007 SHALL have port wbm_sel_i, input, 4*NUM_MANAGERS bits, flat, manager i at [i*4 +: 4]: byte selects.
REQ-008 SHALL have port wbm_ack_o, output, NUM_MANAGERS bits: per-manager acknowledge.
REQ-009 SHALL have port wbm_dat_o, output, 32*NUM_MANAGERS bits, flat: per-manager read data.
REQ-010 SHALL have ports wbs_cyc_o, wbs_stb_o, wbs_we_o, output, 1 bit each: cycle, strobe and write-enable to the decoder.
REQ-011 SHALL have ports wbs_adr_o and wbs_dat_o, output, 32 bits each, and wbs_sel_o, output, 4 bits: address, write data and byte selects to the decoder.
REQ-012 SHALL have port wbs_ack_i, input, 1 bit, and wbs_dat_i, input, 32 bits: acknowledge and read data from the decoder.
REQ-013 SHALL have port grant_o, output, NUM_MANAGERS bits: one-hot current owner, 0 when IDLE.
REQ-014 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on a forced timeout ack.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY, plus a registered grant index, a round-robin pointer last_grant and a 16-bit wait counter.
REQ-016 SHALL treat manager i as requesting when wbm_cyc_i[i] and wbm_stb_i[i] are both 1.
REQ-017 SHALL, in IDLE with any request, grant the first requester scanning from last_grant+1 upward modulo NUM_MANAGERS, load last_grant with it, clear the counter and enter BUSY on the next edge.
REQ-018 SHALL drive all wbs_* outputs, wbm_ack_o, wbm_dat_o and grant_o to 0 in IDLE; this gives 1 cycle of latency from request to downstream strobe.
REQ-019 SHALL, in BUSY, drive wbs_cyc/stb/we/adr/dat/sel_o combinationally from the granted manager's inputs, and drive grant_o one-hot for that manager.
REQ-020 SHALL, in BUSY with wbs_ack_i=1, pass wbs_ack_i and wbs_dat_i combinationally to the granted manager's wbm_ack_o bit and wbm_dat_o slice in the same cycle, then enter IDLE.
REQ-021 SHALL hold wbm_ack_o and wbm_dat_o at 0 for every non-granted manager at all times.
REQ-022 SHALL, in BUSY without ack, increment the counter by 1 per cycle, saturating at 65535.
REQ-023 SHALL, when TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES without ack, in that cycle: force wbs_cyc_o=wbs_stb_o=0, drive ack=1 and dat=32'hDEAD_BEEF to the granted manager, pulse timeout_o, then enter IDLE.
REQ-024 SHALL give a real wbs_ack_i priority over a timeout in the same cycle: normal data, timeout_o=0.
REQ-025 SHALL, if the granted manager deasserts wbm_cyc_i in BUSY (abort), drive wbs_cyc_o=0 and issue no ack that cycle, then enter IDLE; last_grant keeps the aborted manager.
REQ-026 SHALL let a manager that holds cyc&stb after its ack compete again in IDLE; round-robin then favours other requesters.
REQ-027 SHALL never change the owner in BUSY, whatever other requests arrive.

Reset
REQ-028 SHALL, on nRST=0, asynchronously force IDLE, grant index 0, counter 0 and last_grant=NUM_MANAGERS-1, so manager 0 wins first; all outputs then read 0 through the IDLE decode.
REQ-029 SHALL, on nRST assertion mid-BUSY, drop the in-flight transaction with no ack to any manager.

Verification
REQ-030 SHALL cover reset: nRST=0 with all managers requesting -> every output 0, grant_o=0; after release, grant_o=3'b001 one cycle later.
REQ-031 SHALL cover a single read: manager 1 reads 0x3300_0010, decoder acks 2 cycles after wbs_stb_o with 0x1234_5678 -> grant_o=3'b010, wbs_adr_o=0x3300_0010, wbm_ack_o=3'b010 for exactly 1 cycle, wbm_dat_o[63:32]=0x1234_5678.
REQ-032 SHALL cover contention: all three managers hold requests and each drops its strobe after its ack -> grants in order 0,1,2, with one IDLE cycle between transactions.
REQ-033 SHALL cover timeout: TIMEOUT_CYCLES=8, manager 2 writes and no ack arrives -> on the 9th BUSY cycle (counter==8) wbm_ack_o[2]=1, wbm_dat_o slice 2 = 0xDEAD_BEEF, timeout_o=1 for 1 cycle, IDLE next.
REQ-034 SHALL cover abort: manager 0 drops cyc in the 2nd BUSY cycle -> no ack, IDLE next; a pending manager 1 is granted.
REQ-035 SHALL cover ack colliding with timeout: wbs_ack_i=1 exactly at counter==TIMEOUT_CYCLES -> real data delivered, timeout_o=0.
